barrel_shift_checker: RTL

Sequential self-checking receiver for the N-bit barrel shifter's output interface. It accepts one shift transaction per handshake: operand, shift amount, direction and the shifter's reported result. It recomputes the expected value by shifting one bit per clock, compares it against the reported result, and keeps running pass/error statistics. It sits downstream of `BarrelShifter_Nbit` in self-test builds and on-board bring-up, replacing simulation-only checking.

---
 rtl/barrel_shift_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/barrel_shift_checker.sv
// Self-checking receiver for an N-bit barrel shifter: re-derives the expected result one bit
// per clock, compares it with the reported result and keeps saturating pass/error statistics.
module barrel_shift_checker #(
   parameter int unsigned N    = 8,
   parameter int unsigned logN = $clog2(N),
   parameter int unsigned CW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic [logN-1:0] shiftamount,
   input  logic            direction,
   input  logic [N-1:0]    shifted,
   output logic            done,
   output logic            pass,
   output logic [N-1:0]    expected,
   output logic [CW-1:0]   check_count,
   output logic [CW-1:0]   error_count,
   output logic            any_error
);

   typedef enum logic [1:0] {StIdle, StShift, StCompare} state_e;

   localparam logic [CW-1:0] CntMax = '1;

   state_e          state_q, state_d;
   logic [N-1:0]    expected_q, expected_d;
   logic [N-1:0]    shifted_q, shifted_d;
   logic [logN-1:0] rem_q, rem_d;
   logic            dir_q, dir_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [CW-1:0]   check_count_q, check_count_d;
   logic [CW-1:0]   error_count_q, error_count_d;
   logic            any_error_q, any_error_d;
   logic            match;

   assign match = (expected_q == shifted_q);

   always_comb begin
      state_d       = state_q;
      expected_d    = expected_q;
      shifted_d     = shifted_q;
      rem_d         = rem_q;
      dir_d         = dir_q;
      done_d        = 1'b0;
      pass_d        = pass_q;
      check_count_d = check_count_q;
      error_count_d = error_count_q;
      any_error_d   = any_error_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               expected_d = a;
               shifted_d  = shifted;
               rem_d      = shiftamount;
               dir_d      = direction;
               state_d    = StShift;
            end
         end
         StShift: begin
            if (rem_q != '0) begin
               expected_d = dir_q ? (expected_q << 1) : (expected_q >> 1);
               rem_d      = rem_q - 1'b1;
            end else begin
               state_d = StCompare;
               done_d  = 1'b1;
               pass_d  = match;
               if (check_count_q != CntMax) check_count_d = check_count_q + 1'b1;
               if (!match) begin
                  any_error_d = 1'b1;
                  if (error_count_q != CntMax) error_count_d = error_count_q + 1'b1;
               end
            end
         end
         StCompare: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         expected_q    <= '0;
         shifted_q     <= '0;
         rem_q         <= '0;
         dir_q         <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         check_count_q <= '0;
         error_count_q <= '0;
         any_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         shifted_q     <= shifted_d;
         rem_q         <= rem_d;
         dir_q         <= dir_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         check_count_q <= check_count_d;
         error_count_q <= error_count_d;
         any_error_q   <= any_error_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign done        = done_q;
   assign pass        = pass_q;
   assign expected    = expected_q;
   assign check_count = check_count_q;
   assign error_count = error_count_q;
   assign any_error   = any_error_q;

endmodule
